filterbank_msg_sender: RTL and testbench

FILTERBANK_MSG_SENDER -- requirements
Module: filterbank_msg_sender

---
 rtl/filterbank_msg_sender.sv | 180 ++++++++++++++++++
 tb/tb_filterbank_msg_sender.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/filterbank_msg_sender.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | filterbank_msg_sender: buffers N*FLTLEN signed taps and streams them as  |
// | a header word plus one word per tap. Optional FILTERBANK_MSG_CHECKSUM_EN |
// | appends a checksum word. Rev 1.0                                         |
// +--------------------------------------------------------------------------+
module filterbank_msg_sender #(
  parameter int N         = 4,
  parameter int FLTLEN    = 2,
  parameter int LOG_NTAPS = 3,
  parameter int TAP_WIDTH = 16,
  parameter int MSG_WIDTH = 32,
  parameter int GAP       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TAP_WIDTH-1:0] in_tap,
  input  logic                 in_tap_nd,
  input  logic                 start,
  output logic [MSG_WIDTH-1:0] out_msg,
  output logic                 out_msg_nd,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int NTAPS = N * FLTLEN;
  localparam int PW    = LOG_NTAPS + 1;
  localparam int GW    = (GAP > 0) ? $clog2(GAP + 1) : 1;

`ifdef FILTERBANK_MSG_CHECKSUM_EN
  localparam int NWORDS = NTAPS + 2;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_HDR = 3'd1, S_TAPS = 3'd2, S_WAIT = 3'd3, S_CSUM = 3'd4
  } state_t;
`else
  localparam int NWORDS = NTAPS + 1;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0, S_HDR = 2'd1, S_TAPS = 2'd2, S_WAIT = 2'd3
  } state_t;
`endif

  state_t                       state_q, state_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                cnt_q, cnt_d;
  logic [GW-1:0]                gap_q, gap_d;
  logic [MSG_WIDTH-1:0]         out_msg_q, out_msg_d;
  logic                         out_nd_q, out_nd_d;
  logic                         done_q, done_d;
  logic                         error_q, error_d;
  logic signed [TAP_WIDTH-1:0]  tap_mem_q [NTAPS];
  logic                         tap_wr;
  logic                         emit_next;
  logic                         full;
  logic                         busy_w;
  logic [MSG_WIDTH-2:0]         tap_ext;
`ifdef FILTERBANK_MSG_CHECKSUM_EN
  logic [MSG_WIDTH-2:0]         csum_q, csum_d;
`endif

  function automatic logic [MSG_WIDTH-2:0] sext(input logic signed [TAP_WIDTH-1:0] t);
    return (MSG_WIDTH-1)'(t);
  endfunction

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    out_msg_d = out_msg_q;
    out_nd_d  = 1'b0;
    done_d    = 1'b0;
    error_d   = error_q;
    tap_wr    = 1'b0;
    emit_next = 1'b0;
`ifdef FILTERBANK_MSG_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    full    = (wr_ptr_q == PW'(NTAPS));
    busy_w  = (state_q != S_IDLE);
    tap_ext = sext(tap_mem_q[cnt_q[LOG_NTAPS-1:0]]);

    if (in_tap_nd) begin
      if (busy_w || full) begin
        error_d = 1'b1;
      end else begin
        tap_wr   = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
    end
    if (start && (busy_w || !full)) error_d = 1'b1;

    // cnt_q is the index of the word currently on out_msg (0 = header)
    case (state_q)
      S_IDLE: begin
        if (start && full) begin
          state_d   = S_HDR;
          cnt_d     = '0;
          out_msg_d = {1'b1, (MSG_WIDTH-1)'(NTAPS)};
          out_nd_d  = 1'b1;
`ifdef FILTERBANK_MSG_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end
      S_WAIT: begin
        if (gap_q == '0) emit_next = 1'b1;
        else             gap_d = gap_q - GW'(1);
      end
      default: begin
        if (cnt_q == PW'(NWORDS - 1)) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          wr_ptr_d = '0;
        end else if (GAP == 0) begin
          emit_next = 1'b1;
        end else begin
          state_d = S_WAIT;
          gap_d   = GW'(GAP - 1);
        end
      end
    endcase

    if (emit_next) begin
      cnt_d    = cnt_q + PW'(1);
      out_nd_d = 1'b1;
      if (cnt_q < PW'(NTAPS)) begin
        state_d   = S_TAPS;
        out_msg_d = {1'b0, tap_ext};
`ifdef FILTERBANK_MSG_CHECKSUM_EN
        csum_d    = csum_q + tap_ext;
      end else begin
        state_d   = S_CSUM;
        out_msg_d = {1'b0, csum_q};
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      out_msg_q <= '0;
      out_nd_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef FILTERBANK_MSG_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      out_msg_q <= out_msg_d;
      out_nd_q  <= out_nd_d;
      done_q    <= done_d;
      error_q   <= error_d;
`ifdef FILTERBANK_MSG_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // Tap storage needs no reset; contents only matter once the pointer says full.
  always_ff @(posedge clk) begin
    if (tap_wr) tap_mem_q[wr_ptr_q[LOG_NTAPS-1:0]] <= in_tap;
  end

  assign out_msg    = out_msg_q;
  assign out_msg_nd = out_nd_q;
  assign busy       = busy_w;
  assign done       = done_q;
  assign error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_filterbank_msg_sender.sv
`default_nettype none
// Bench for filterbank_msg_sender: one GAP=0 and one GAP=2 instance driven with
// identical stimulus, checked against hand-coded vectors and a queue-based model.
module tb_filterbank_msg_sender;
  localparam int NT = 8;

  typedef logic [31:0] wq_t[$];
  typedef struct { int t; logic [31:0] w; } ev_t;
  typedef ev_t evq_t[$];
  typedef struct packed {
    logic [127:0] taps;
    logic [287:0] exp;
    logic [31:0]  csum;
    logic         disturb;
  } vec_t;

  logic        clk, rst, in_tap_nd, start;
  logic [15:0] in_tap;
  logic [31:0] out_msg0, out_msg1;
  logic        nd0, nd1, busy0, busy1, done0, done1, err0, err1;

  filterbank_msg_sender #(.GAP(0)) u_g0 (
    .clk(clk), .rst(rst), .in_tap(in_tap), .in_tap_nd(in_tap_nd), .start(start),
    .out_msg(out_msg0), .out_msg_nd(nd0), .busy(busy0), .done(done0), .error(err0));
  filterbank_msg_sender #(.GAP(2)) u_g2 (
    .clk(clk), .rst(rst), .in_tap(in_tap), .in_tap_nd(in_tap_nd), .start(start),
    .out_msg(out_msg1), .out_msg_nd(nd1), .busy(busy1), .done(done1), .error(err1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  evq_t q0, q1;
  int   d0[$], d1[$];
  int   bc0, bc1;
  always @(negedge clk) begin
    if (nd0) q0.push_back('{t: cyc, w: out_msg0});
    if (nd1) q1.push_back('{t: cyc, w: out_msg1});
    if (done0) d0.push_back(cyc);
    if (done1) d1.push_back(cyc);
    if (busy0) bc0++;
    if (busy1) bc1++;
  end

  int          n_pass = 0, n_total = 0;
  logic [15:0] mtaps[$];
  logic        merr;
  vec_t        tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q0.delete(); q1.delete(); d0.delete(); d1.delete();
    bc0 = 0; bc1 = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_tap_nd = 1'b0;
    tick(); tick();
    rst = 1'b0;
    mtaps.delete(); merr = 1'b0;
  endtask

  task automatic write_tap(input logic [15:0] v);
    in_tap = v; in_tap_nd = 1'b1;
    tick();
    in_tap_nd = 1'b0;
    if (mtaps.size() < NT) mtaps.push_back(v);
    else merr = 1'b1;
  endtask

  // Expected stream from the accepted taps: header, sign-extended taps, optional sum.
  function automatic wq_t model_words();
    wq_t    w;
    longint sum = 0;
    w.push_back(32'h8000_0000 | 32'(NT));
    foreach (mtaps[i]) begin
      int v = int'($signed(mtaps[i]));
      sum += v;
      w.push_back(32'(v) & 32'h7FFF_FFFF);
    end
`ifdef FILTERBANK_MSG_CHECKSUM_EN
    w.push_back(32'(sum) & 32'h7FFF_FFFF);
`endif
    return w;
  endfunction

  task automatic check_dut(input string tag, input int g, input int t0, input wq_t ex,
                           input evq_t q, input int dq[$], input int bc);
    int nw = ex.size();
    check({tag, " nwords"}, q.size(), nw);
    for (int j = 0; j < nw && j < q.size(); j++) begin
      check($sformatf("%s word%0d", tag, j), q[j].w, ex[j]);
      check($sformatf("%s time%0d", tag, j), q[j].t, t0 + 1 + j * (g + 1));
    end
    check({tag, " done_count"}, dq.size(), 1);
    if (dq.size() > 0) check({tag, " done_time"}, dq[0], t0 + 2 + (nw - 1) * (g + 1));
    check({tag, " busy_cycles"}, bc, 1 + (nw - 1) * (g + 1));
  endtask

  task automatic transmit(input wq_t ex, input bit disturb);
    int t0;
    clear_mon();
    start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (d0.size() > 0 && d1.size() > 0) break;
      if (disturb && k == 2) begin
        start = 1'b1; in_tap = 16'($urandom); in_tap_nd = 1'b1; merr = 1'b1;
      end else begin
        start = 1'b0; in_tap_nd = 1'b0;
      end
      tick();
    end
    start = 1'b0; in_tap_nd = 1'b0;
    tick(); tick();
    mtaps.delete();
    check_dut("g0", 0, t0, ex, q0, d0, bc0);
    check_dut("g2", 2, t0, ex, q1, d1, bc1);
    check("g0 busy_after", busy0, 0);
    check("g2 busy_after", busy1, 0);
    check("g0 error", err0, merr);
    check("g2 error", err1, merr);
  endtask

  task automatic start_reject();
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0; merr = 1'b1;
    repeat (12) tick();
    check("rej g0 words", q0.size(), 0);
    check("rej g2 words", q1.size(), 0);
    check("rej g0 busy", busy0, 0);
    check("rej g0 error", err0, merr);
    check("rej g2 error", err1, merr);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " g0 out_msg"}, out_msg0, 0);
    check({tag, " g0 nd"}, nd0, 0);
    check({tag, " g0 busy"}, busy0, 0);
    check({tag, " g0 done"}, done0, 0);
    check({tag, " g0 error"}, err0, 0);
    check({tag, " g2 out_msg"}, out_msg1, 0);
    check({tag, " g2 nd"}, nd1, 0);
    check({tag, " g2 busy"}, busy1, 0);
    check({tag, " g2 done"}, done1, 0);
    check({tag, " g2 error"}, err1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, late0, late1;
    wq_t ex;
    rst = 1'b1; start = 1'b0; in_tap_nd = 1'b0; in_tap = '0; merr = 1'b0;

    tbl[0] = '{taps: {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8},
               exp: {32'h8000_0008, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8},
               csum: 32'h24, disturb: 1'b0};
    tbl[1] = '{taps: {16'hFFFF, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7},
               exp: {32'h8000_0008, 32'h7FFF_FFFF, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7},
               csum: 32'h1B, disturb: 1'b0};
    tbl[2] = '{taps: {16'h7FFF, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1},
               exp: {32'h8000_0008, 32'h0000_7FFF, 32'h7FFF_8000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1},
               csum: 32'h0, disturb: 1'b0};
    tbl[3] = '{taps: {8{16'hFFFF}}, exp: {32'h8000_0008, {8{32'h7FFF_FFFF}}},
               csum: 32'h7FFF_FFF8, disturb: 1'b0};
    tbl[4] = tbl[0];
    tbl[4].disturb = 1'b1;

    do_reset();
    check_zero("reset");

    foreach (tbl[e]) begin
      for (int i = 0; i < NT; i++) write_tap(tbl[e].taps[(7 - i) * 16 +: 16]);
      ex = {};
      for (int j = 0; j < 9; j++) ex.push_back(tbl[e].exp[(8 - j) * 32 +: 32]);
`ifdef FILTERBANK_MSG_CHECKSUM_EN
      ex.push_back(tbl[e].csum);
`endif
      transmit(ex, tbl[e].disturb);
    end

    // Start with a partial buffer, then overflow by one write.
    do_reset();
    for (int i = 0; i < 5; i++) write_tap(16'(i + 1));
    start_reject();
    for (int i = 5; i < 9; i++) write_tap(16'(i + 1));
    transmit(model_words(), 1'b0);

    // Final write and start in the same cycle: write lands, start is refused.
    do_reset();
    for (int i = 0; i < 7; i++) write_tap(16'($urandom));
    clear_mon();
    in_tap = 16'h1234; in_tap_nd = 1'b1; start = 1'b1;
    tick();
    in_tap_nd = 1'b0; start = 1'b0;
    mtaps.push_back(16'h1234); merr = 1'b1;
    repeat (12) tick();
    check("same_cycle g0 words", q0.size(), 0);
    check("same_cycle g2 words", q1.size(), 0);
    check("same_cycle g0 error", err0, 1);
    transmit(model_words(), 1'b0);

    // Reset while the fourth tap word is on the GAP=0 output.
    do_reset();
    for (int i = 0; i < NT; i++) write_tap(16'($urandom));
    clear_mon();
    start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
    while (cyc < t0 + 5) tick();
    check("pre_abort g0 nd", nd0, 1);
    rst = 1'b1;
    tick();
    check_zero("abort");
    rst = 1'b0; mtaps.delete(); merr = 1'b0;
    repeat (30) tick();
    late0 = 0; late1 = 0;
    foreach (q0[i]) if (q0[i].t > t0 + 5) late0++;
    foreach (q1[i]) if (q1[i].t > t0 + 5) late1++;
    check("abort g0 late_words", late0, 0);
    check("abort g2 late_words", late1, 0);
    check("abort g0 done", d0.size(), 0);
    for (int i = 0; i < NT; i++) write_tap(16'($urandom));
    transmit(model_words(), 1'b0);

    for (int it = 0; it < 8; it++) begin
      int n = $urandom_range(5, 9);
      if ($urandom_range(0, 3) == 0) do_reset();
      for (int i = 0; i < n; i++) write_tap(16'($urandom));
      if (mtaps.size() < NT) begin
        start_reject();
        while (mtaps.size() < NT) write_tap(16'($urandom));
      end
      transmit(model_words(), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
